ice51_uart_loader: RTL and testbench
====================================

Name: ice51_uart_loader

Overview:
- UART receive end of the ice51 serial link, sitting between the i_uart_rx pin and the code memory / core UART.
- Deserialises 8N1 frames at 115200 baud from a 12 MHz clock.
- After reset, writes the first MEM_SIZE received bytes into code memory at sequential addresses, then releases the core.
- Every later byte is handed to the core as ordinary UART receive data.

Parameters:
CLK_PER_BIT, 104, clocks per UART bit (12 MHz / 115200, truncated)
MEM_SIZE, 1024, number of bytes loaded into code memory after reset
ADDR_W, 10, code memory address width; MEM_SIZE <= 2**ADDR_W
PRELOAD, 0, 1 = skip the load phase; o_load_done is high directly after reset

Ports:
i_clk  in  1  system clock, 12 MHz
i_rst  in  1  asynchronous reset, active high
i_uart_rx  in  1  serial input, idle high, asynchronous to i_clk
o_mem_we  out  1  code memory write strobe, one-cycle pulse
o_mem_addr  out  ADDR_W  code memory write address
o_mem_data  out  8  code memory write data
o_load_done  out  1  high once the load phase is complete; used as the core reset release
o_rx_valid  out  1  one-cycle pulse: o_rx_data holds a post-load byte
o_rx_data  out  8  received byte for the core UART
o_frame_err  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
Reset values:
- o_mem_we, o_rx_valid, o_frame_err = 0.
- o_mem_addr = 0, o_mem_data = 0, o_rx_data = 0.
- o_load_done = PRELOAD.
- Both synchroniser flops = 1. FSM = IDLE. Bit and byte counters = 0.

Input synchronisation:
- 2-flop synchroniser on i_uart_rx; all logic uses the second flop (rx_s).
- This adds 2 cycles of latency.

Receive FSM (IDLE, START, DATA, STOP, WAIT_IDLE):
- IDLE: rx_s == 0 -> START and clear the bit timer. Call that cycle t0.
- START: at t0 + CLK_PER_BIT/2 (t0+52), sample rx_s.
  - Sample 0 -> DATA.
  - Sample 1 -> glitch; return to IDLE with no output.
- DATA: sample rx_s every CLK_PER_BIT (t0+156, +260, ... +884).
  - Shift in LSB first; exactly 8 samples -> STOP.
- STOP: sample at t0+988.
  - Sample 1: byte is good, go to IDLE.
  - Sample 0: pulse o_frame_err at t0+989, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s == 1, then IDLE. A line held low produces no repeated frames.
- A new start bit is accepted from the cycle after the stop sample (back-to-back frames are supported).

Byte routing (cycle t0+989, good byte only):
- o_load_done == 0:
  - Assert o_mem_we for 1 cycle, o_mem_data = byte, o_mem_addr = load counter.
  - The counter increments after the write.
  - On the write with counter == MEM_SIZE-1: counter wraps to 0 and o_load_done rises on the next cycle. It stays high until reset.
- o_load_done == 1:
  - Pulse o_rx_valid for 1 cycle; o_rx_data = byte.
  - o_rx_data holds its value until the next good byte.
  - o_mem_we never asserts again.
- o_mem_we and o_rx_valid are never high in the same cycle.
- A byte that completes on the same cycle o_load_done rises has already been written to memory. It is not forwarded.

Timing:
- End-to-end latency from the i_uart_rx falling edge to the output strobe: 2 + 989 cycles, ±1 cycle of edge alignment.

Reset mid-operation:
- Async i_rst mid-frame or mid-load aborts immediately and all state returns to reset values.
- Load restarts at address 0. A partially received frame is lost.

Test Plan:
1. PRELOAD=0, MEM_SIZE=4: send 0x12,0x34,0x56,0x78 -> o_mem_we ×4 with addr 0..3 / matching data; o_load_done rises 1 cycle after the 4th write.
2. Continue from (1): send 0xA5 -> o_rx_valid pulse with o_rx_data=0xA5, no o_mem_we; strobe within 991±1 cycles of the start edge.
3. Glitch: drive i_uart_rx low for 20 cycles, then high -> no outputs, FSM back in IDLE. A following 0x3C frame is received correctly.
4. Frame error: send 0x55 with stop bit 0, then hold the line low 2000 cycles, then release -> single o_frame_err pulse, no write, load counter unchanged. A next 0x66 is written to the same address.
5. Reset mid-load: after 2 of 4 bytes, pulse i_rst during the 3rd frame -> outputs reset, o_load_done=0. Resend 4 bytes -> writes begin at address 0.
6. PRELOAD=1: o_load_done=1 out of reset. Send 0xFF and 0x00 back-to-back -> two o_rx_valid pulses, data 0xFF then 0x00, o_mem_we never asserted.

Source files
------------

// File: rtl/ice51_uart_loader.sv
// ice51 serial receive path: 8N1 deserialiser that fills code memory with the
// first MEM_SIZE bytes after reset, then forwards later bytes to the core UART.
module ice51_uart_loader #(
    parameter int CLK_PER_BIT = 104,
    parameter int MEM_SIZE    = 1024,
    parameter int ADDR_W      = 10,
    parameter int PRELOAD     = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_uart_rx,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic              o_load_done,
    output logic              o_rx_valid,
    output logic [7:0]        o_rx_data,
    output logic              o_frame_err
);

    localparam int                TW        = $clog2(CLK_PER_BIT);
    localparam logic [TW-1:0]     HALF_M1   = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]     FULL_M1   = TW'(CLK_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
    localparam logic              DONE_RST  = (PRELOAD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_rx_meta;
    logic                r_rx_s;
    logic [TW-1:0]       r_timer;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [ADDR_W-1:0]   r_load_cnt;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_data;
    logic                r_load_done;
    logic                r_rx_valid;
    logic [7:0]          r_rx_data;
    logic                r_frame_err;
    logic                w_timer_clr;
    logic                w_start_ok;
    logic                w_shift;
    logic                w_byte_ok;
    logic                w_frame_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_uart_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bit timer is cleared on entering START (t0), at the mid-start sample and
    // at every data sample, so each later sample lands one bit period apart.
    always_comb begin
        w_state_next = r_state;
        w_timer_clr  = 1'b0;
        w_start_ok   = 1'b0;
        w_shift      = 1'b0;
        w_byte_ok    = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = S_START;
                    w_timer_clr  = 1'b1;
                end
            end
            S_START: begin
                if (r_timer == HALF_M1) begin
                    w_timer_clr = 1'b1;
                    if (r_rx_s) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                        w_start_ok   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (r_timer == FULL_M1) begin
                    w_timer_clr = 1'b1;
                    w_shift     = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_timer == FULL_M1) begin
                    w_timer_clr = 1'b1;
                    if (r_rx_s) begin
                        w_byte_ok    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_timer <= w_timer_clr ? '0 : r_timer + TW'(1);
            if (w_start_ok) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_shift) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
        end
    end

    // Load completion is taken from the registered last write, so o_load_done
    // rises the cycle after the final memory strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_load_cnt  <= '0;
            r_load_done <= DONE_RST;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_mem_we    <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= w_frame_err;
            if (r_mem_we && (r_mem_addr == LAST_ADDR)) begin
                r_load_done <= 1'b1;
            end
            if (w_byte_ok) begin
                if (!r_load_done) begin
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= r_load_cnt;
                    r_mem_data <= r_shift;
                    r_load_cnt <= (r_load_cnt == LAST_ADDR) ? '0 : r_load_cnt + ADDR_W'(1);
                end else begin
                    r_rx_valid <= 1'b1;
                    r_rx_data  <= r_shift;
                end
            end
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_data  = r_mem_data;
    assign o_load_done = r_load_done;
    assign o_rx_valid  = r_rx_valid;
    assign o_rx_data   = r_rx_data;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_ice51_uart_loader.sv
// Bench for ice51_uart_loader: lane 0 loads a 4-byte memory, lane 1 is preloaded.
// Expected strobes come from a byte-level routing model queued per sent frame.
module tb_ice51_uart_loader;

    localparam int CPB = 104;
    localparam int MSZ = 4;
    localparam int AW  = 10;

    typedef struct {
        int     kind;   // 0 = memory write, 1 = rx byte, 2 = frame error
        int     lane;
        int     addr;
        int     data;
        longint start;
    } evt_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx0 = 1'b1;
    logic          rx1 = 1'b1;
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [7:0]    mem_data  [2];
    logic          load_done [2];
    logic          rx_valid  [2];
    logic [7:0]    rx_data   [2];
    logic          frame_err [2];

    longint cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;
    evt_t   exp_q[$];
    int     m_loaded = 0;
    int     m_last_rx [2] = '{0, 0};
    bit     done_pending = 1'b0;

    ice51_uart_loader #(.CLK_PER_BIT(CPB), .MEM_SIZE(MSZ), .ADDR_W(AW), .PRELOAD(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx0),
        .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]), .o_mem_data(mem_data[0]),
        .o_load_done(load_done[0]), .o_rx_valid(rx_valid[0]), .o_rx_data(rx_data[0]),
        .o_frame_err(frame_err[0])
    );

    ice51_uart_loader #(.CLK_PER_BIT(CPB), .MEM_SIZE(MSZ), .ADDR_W(AW), .PRELOAD(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx1),
        .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]), .o_mem_data(mem_data[1]),
        .o_load_done(load_done[1]), .o_rx_valid(rx_valid[1]), .o_rx_data(rx_data[1]),
        .o_frame_err(frame_err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic set_rx(input int lane, input logic v);
        if (lane == 0) rx0 = v;
        else rx1 = v;
    endtask

    // Reference routing: bad stop -> frame error; otherwise the first MSZ good
    // bytes after reset on the loading lane go to memory, everything else to the core.
    task automatic model_frame(input int lane, input logic [7:0] b, input logic stop_b, input longint t);
        evt_t e;
        e.lane = lane; e.addr = 0; e.data = b; e.start = t;
        if (!stop_b) e.kind = 2;
        else if (lane == 0 && m_loaded < MSZ) begin
            e.kind = 0; e.addr = m_loaded; m_loaded++;
        end else begin
            e.kind = 1; m_last_rx[lane] = b;
        end
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input int lane, input logic [7:0] b, input logic stop_b);
        @(posedge clk); #1;
        set_rx(lane, 1'b0);
        model_frame(lane, b, stop_b, cyc);
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 set_rx(lane, b[i]);
            repeat (CPB) @(posedge clk);
        end
        #1 set_rx(lane, stop_b);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check(tag, exp_q.size(), 0);
        idle(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int l = 0; l < 2; l++) begin
            check({tag, "_we"}, mem_we[l], 0);
            check({tag, "_addr"}, mem_addr[l], 0);
            check({tag, "_mdata"}, mem_data[l], 0);
            check({tag, "_valid"}, rx_valid[l], 0);
            check({tag, "_rxdata"}, rx_data[l], 0);
            check({tag, "_ferr"}, frame_err[l], 0);
            check({tag, "_done"}, load_done[l], l);
        end
    endtask

    always @(negedge clk) begin
        evt_t   e;
        longint d;
        int     k;
        if (done_pending) begin
            check("load_done_rise", load_done[0], 1);
            done_pending = 1'b0;
        end
        for (int l = 0; l < 2; l++) begin
            if (!rst && (mem_we[l] || rx_valid[l] || frame_err[l])) begin
                check("we_valid_exclusive", mem_we[l] & rx_valid[l], 0);
                k = mem_we[l] ? 0 : (rx_valid[l] ? 1 : 2);
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", {mem_we[l], rx_valid[l], frame_err[l]}, 0);
                end else begin
                    e = exp_q.pop_front();
                    d = cyc - e.start;
                    check("strobe_lane", l, e.lane);
                    check("strobe_kind", k, e.kind);
                    check("latency", (d >= 990 && d <= 992) ? 991 : d, 991);
                    if (e.kind == 0) begin
                        check("mem_addr", mem_addr[l], e.addr);
                        check("mem_data", mem_data[l], e.data);
                        check("done_low_at_write", load_done[l], 0);
                        if (e.addr == MSZ - 1) done_pending = 1'b1;
                    end else if (e.kind == 1) begin
                        check("rx_data", rx_data[l], e.data);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] load_bytes [4];
        load_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};

        idle(3);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        idle(5);

        // Short low pulse must be rejected at the mid-start sample.
        rx0 = 1'b0; idle(20); rx0 = 1'b1; idle(100);
        check("glitch_no_write", mem_addr[0], 0);
        send_frame(0, 8'h3C, 1'b1);
        drain("drain_after_glitch");

        // Bad stop bit, then a stuck-low line: one error pulse only.
        send_frame(0, 8'h55, 1'b0);
        idle(2000);
        rx0 = 1'b1; idle(50);
        drain("drain_frame_err");
        send_frame(0, 8'h66, 1'b1);
        drain("drain_after_ferr");
        check("done_still_low", load_done[0], 0);

        // Reset in the middle of the third load frame.
        @(posedge clk); #1 rx0 = 1'b0;
        idle(CPB * 3 + 17);
        rst = 1'b1; #1;
        check_reset_outputs("midload_reset");
        rx0 = 1'b1;
        exp_q.delete();
        m_loaded = 0;
        m_last_rx = '{0, 0};
        idle(10);
        rst = 1'b0;
        idle(5);

        for (int i = 0; i < 4; i++) begin
            send_frame(0, load_bytes[i], 1'b1);
            idle($urandom_range(0, 20));
        end
        drain("drain_load");
        check("load_done_final", load_done[0], 1);

        send_frame(0, 8'hA5, 1'b1);
        drain("drain_a5");
        for (int i = 0; i < 5; i++) begin
            send_frame(0, 8'($urandom_range(0, 255)), 1'b1);
            idle(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 40));
        end
        drain("drain_random0");
        check("rx_data_hold0", rx_data[0], m_last_rx[0]);
        check("load_done_sticky", load_done[0], 1);

        // Preloaded instance: everything is core data, back-to-back frames.
        send_frame(1, 8'hFF, 1'b1);
        send_frame(1, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_frame(1, 8'($urandom_range(0, 255)), 1'b1);
            idle($urandom_range(0, 30));
        end
        drain("drain_random1");
        check("rx_data_hold1", rx_data[1], m_last_rx[1]);
        check("preload_addr_idle", mem_addr[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
